// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, default
// frame width, legal oversampling ratios and the parity helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_8     = 8;
  localparam int PRESCALE_16    = 16;
  localparam int PRESCALE_32    = 32;

  // Expected parity bit from the XOR-reduction of the data (odd flips it).
  function automatic logic exp_parity(input logic xor_data, input logic odd);
    return xor_data ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority-vote bit sampler: captures rx_s at mid-bit-1 and
// mid-bit, and votes with the live value at mid-bit+1.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_s_i,
  input  logic [PRESCALE_W-1:0] edge_cnt_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  sampled_o,
  output logic                  sample_done_o
);

  logic [PRESCALE_W-1:0] half_s;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;

  assign half_s = prescale_i >> 1;

  // Pick which of the first two sample slots is written this cycle.
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    if (edge_cnt_i == (half_s - PRESCALE_W'(1))) begin
      s0_d = rx_s_i;
    end else if (edge_cnt_i == half_s) begin
      s1_d = rx_s_i;
    end else begin
      s0_d = s0_q;
      s1_d = s1_q;
    end
  end

  // Sample slot registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign sample_done_o = (edge_cnt_i == (half_s + PRESCALE_W'(1)));
  assign sampled_o     = (s0_q & s1_q) | (s0_q & rx_s_i) | (s1_q & rx_s_i);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, bit/edge counters, shift register
// and parity/stop checking with one-cycle registered result pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  sync1_q, rx_s_q;
  logic [PRESCALE_W-1:0] edge_q, edge_d, ps_q, ps_d, next_edge_s;
  logic [BCW-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  glitch_q, glitch_d, par_bad_q, par_bad_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic                  wrap_s, sampled_s, sample_done_s;

  // Two-flop synchronizer, idles high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk_i         (CLK),
    .rst_i         (RST),
    .rx_s_i        (rx_s_q),
    .edge_cnt_i    (edge_q),
    .prescale_i    (ps_q),
    .sampled_o     (sampled_s),
    .sample_done_o (sample_done_s)
  );

  assign wrap_s      = (edge_q == (ps_q - PRESCALE_W'(1)));
  assign next_edge_s = wrap_s ? '0 : (edge_q + PRESCALE_W'(1));

  // Next-state logic; frame config is frozen in *_q from start detection on.
  always_comb begin
    state_d   = state_q;
    edge_d    = next_edge_s;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    ps_d      = ps_q;
    glitch_d  = glitch_q;
    par_bad_d = par_bad_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_s_q) begin
          state_d   = ST_START;
          edge_d    = PRESCALE_W'(1);
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          ps_d      = Prescale;
          glitch_d  = 1'b0;
          par_bad_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_done_s) begin
          glitch_d = sampled_s;
        end else begin
          glitch_d = glitch_q;
        end
        if (wrap_s) begin
          state_d = glitch_q ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_done_s) begin
          shift_d = {sampled_s, shift_q[DATA_WIDTH-1:1]};
        end else begin
          shift_d = shift_q;
        end
        if (wrap_s && (bit_q == LAST_BIT)) begin
          bit_d   = '0;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else if (wrap_s) begin
          bit_d = bit_q + BCW'(1);
        end else begin
          bit_d = bit_q;
        end
      end
      ST_PARITY: begin
        if (sample_done_s) begin
          par_bad_d = (sampled_s != exp_parity(^shift_q, par_typ_q));
        end else begin
          par_bad_d = par_bad_q;
        end
        if (wrap_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        // Leave at the last sample so a directly following start bit is seen.
        if (sample_done_s) begin
          state_d = ST_IDLE;
          edge_d  = '0;
          se_d    = ~sampled_s;
          pe_d    = par_bad_q;
          if (sampled_s && !par_bad_q) begin
            dv_d    = 1'b1;
            pdata_d = shift_q;
          end else begin
            dv_d    = 1'b0;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        edge_d  = '0;
      end
    endcase
  end

  // State, counters, datapath and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      ps_q      <= PRESCALE_W'(PRESCALE_8);
      glitch_q  <= 1'b0;
      par_bad_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      ps_q      <= ps_d;
      glitch_q  <= glitch_d;
      par_bad_q <= par_bad_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = pe_q;
  assign Stop_Err   = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed, table-driven bench for uart_rx: frames are driven on RX_IN and
// result pulses are collected by a negedge monitor and compared per frame.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_Err, Stop_Err;

  int n_checks = 0;
  int n_fail = 0;

  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, dbl_cnt = 0;
  logic pdv = 1'b0, ppe = 1'b0, pse = 1'b0;
  logic [7:0] dvq[$];

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Par_Err(Par_Err), .Stop_Err(Stop_Err)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor: counts flags, records received data, flags wide pulses.
  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_cnt <= dv_cnt + 1;
      dvq.push_back(P_DATA);
    end
    if (Par_Err)  pe_cnt <= pe_cnt + 1;
    if (Stop_Err) se_cnt <= se_cnt + 1;
    if ((Data_Valid && pdv) || (Par_Err && ppe) || (Stop_Err && pse))
      dbl_cnt <= dbl_cnt + 1;
    pdv <= Data_Valid;
    ppe <= Par_Err;
    pse <= Stop_Err;
  end

  typedef struct {
    int         ps;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         par;
    bit         stop;
    bit         scr;
    int         e_dv;
    int         e_pe;
    int         e_se;
    logic [7:0] e_pd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int ps, input bit pe, input bit pt, input logic [7:0] d,
                            input bit par, input bit stop, input bit scr);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    Prescale = 6'(ps);
    RX_IN    = 1'b0;
    repeat (ps) @(negedge CLK);
    if (scr) begin
      PAR_EN   = ~pe;
      PAR_TYP  = ~pt;
      Prescale = (ps == 16) ? 6'd8 : 6'd16;
    end
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (ps) @(negedge CLK);
    end
    if (pe) begin
      RX_IN = par;
      repeat (ps) @(negedge CLK);
    end
    RX_IN = stop;
    repeat (ps) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  initial begin
    int b_dv, b_pe, b_se, b_q;

    vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
    vecs[1] = '{16, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 0, 1, 0, 8'hA5};
    vecs[2] = '{8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
    vecs[3] = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h55};
    vecs[4] = '{16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'hC3};
    vecs[5] = '{32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h01};
    vecs[6] = '{8,  1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 0, 1, 1, 8'h01};
    vecs[7] = '{16, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'h96};

    repeat (4) @(negedge CLK);
    check("reset P_DATA", 32'(P_DATA), 32'h0);
    check("reset Data_Valid", 32'(Data_Valid), 32'h0);
    check("reset Par_Err", 32'(Par_Err), 32'h0);
    check("reset Stop_Err", 32'(Stop_Err), 32'h0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    for (int v = 0; v < 8; v++) begin
      b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
      send_frame(vecs[v].ps, vecs[v].pe, vecs[v].pt, vecs[v].data,
                 vecs[v].par, vecs[v].stop, vecs[v].scr);
      repeat (4 * vecs[v].ps) @(negedge CLK);
      check($sformatf("vec%0d dv count", v), 32'(dv_cnt - b_dv), 32'(vecs[v].e_dv));
      check($sformatf("vec%0d par_err count", v), 32'(pe_cnt - b_pe), 32'(vecs[v].e_pe));
      check($sformatf("vec%0d stop_err count", v), 32'(se_cnt - b_se), 32'(vecs[v].e_se));
      check($sformatf("vec%0d P_DATA", v), 32'(P_DATA), 32'(vecs[v].e_pd));
    end

    // Start-bit glitch, then a good frame.
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    PAR_EN = 1'b0; Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (32) @(negedge CLK);
    check("glitch pulses", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'h0);
    send_frame(8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0);
    repeat (32) @(negedge CLK);
    check("post-glitch dv count", 32'(dv_cnt - b_dv), 32'h1);
    check("post-glitch P_DATA", 32'(P_DATA), 32'h0F);

    // Back-to-back frames at Prescale 32 with no idle gap.
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; b_q = dvq.size();
    send_frame(32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
    repeat (128) @(negedge CLK);
    check("b2b dv count", 32'(dv_cnt - b_dv), 32'h3);
    check("b2b err count", 32'((pe_cnt - b_pe) + (se_cnt - b_se)), 32'h0);
    check("b2b data0", (dvq.size() > b_q + 0) ? 32'(dvq[b_q + 0]) : 32'hDEAD, 32'h00);
    check("b2b data1", (dvq.size() > b_q + 1) ? 32'(dvq[b_q + 1]) : 32'hDEAD, 32'hFF);
    check("b2b data2", (dvq.size() > b_q + 2) ? 32'(dvq[b_q + 2]) : 32'hDEAD, 32'h81);

    // Reset during bit 4 of 0x77, then a clean 0x77 frame.
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    PAR_EN = 1'b0; Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX_IN = (i == 3) ? 1'b0 : 1'b1;
      repeat (8) @(negedge CLK);
    end
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid-reset P_DATA", 32'(P_DATA), 32'h0);
    check("mid-reset flags", 32'({Data_Valid, Par_Err, Stop_Err}), 32'h0);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    check("mid-reset pulses", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'h0);
    send_frame(8, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0);
    repeat (32) @(negedge CLK);
    check("post-reset dv count", 32'(dv_cnt - b_dv), 32'h1);
    check("post-reset P_DATA", 32'(P_DATA), 32'h77);

    check("pulse width", 32'(dbl_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
